// File: rtl/bitmap_dram_arbiter_pkg.sv
// Shared types and constants for the bitmap DRAM arbiter: FSM state encoding,
// nibble-select values and default geometry/latency parameters.
package bitmap_dram_arbiter_pkg;

    localparam int AW_DEF           = 15;
    localparam int DW_DEF           = 8;
    localparam int VID_MAX_WAIT_DEF = 3;

    localparam logic NIB_HI = 1'b1;
    localparam logic NIB_LO = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_VRD  = 4'd1,
        ST_VCAP = 4'd2,
        ST_CRD  = 4'd3,
        ST_CCAP = 4'd4,
        ST_CWR  = 4'd5,
        ST_BRD  = 4'd6,
        ST_BCAP = 4'd7,
        ST_BWR  = 4'd8
    } state_e;

endpackage

// File: rtl/bitmap_dram_arbiter_if.sv
// Bundle of the video-fetch, CPU and DRAM-array signals around the arbiter.
// slave is the arbiter's view; master is the surrounding system's view.
interface bitmap_dram_arbiter_if import bitmap_dram_arbiter_pkg::*; #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;

    logic          cpu_req;
    logic          cpu_we;
    logic          cpu_bitmd;
    logic          cpu_pixa;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  vid_req, vid_addr,
        output vid_data, vid_valid,
        input  cpu_req, cpu_we, cpu_bitmd, cpu_pixa, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output vid_req, vid_addr,
        input  vid_data, vid_valid,
        output cpu_req, cpu_we, cpu_bitmd, cpu_pixa, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/bitmap_dram_arbiter_chk.sv
// Simulation-only checks: video request overrun and video fetch latency bound.
module bitmap_dram_arbiter_chk #(
    parameter int VID_MAX_WAIT = 3
) (
    input logic clk,
    input logic reset,
    input logic vid_req,
    input logic vid_pend,
    input logic vid_valid
);

    logic [3:0] wait_q;
    logic       waiting_q;

    // Cycles elapsed since the oldest outstanding video request
    always_ff @(posedge clk) begin
        if (reset) begin
            waiting_q <= 1'b0;
            wait_q    <= 4'd0;
        end else if (vid_valid) begin
            waiting_q <= 1'b0;
            wait_q    <= 4'd0;
        end else if (vid_req && !waiting_q) begin
            waiting_q <= 1'b1;
            wait_q    <= 4'd1;
        end else if (waiting_q) begin
            waiting_q <= 1'b1;
            wait_q    <= wait_q + 4'd1;
        end else begin
            waiting_q <= 1'b0;
            wait_q    <= 4'd0;
        end
    end

    a_vid_overrun: assert property (@(posedge clk) disable iff (reset)
        !(vid_req && vid_pend));

    a_vid_latency: assert property (@(posedge clk) disable iff (reset)
        !(waiting_q && (wait_q > 4'(VID_MAX_WAIT + 3))));

endmodule

// File: rtl/bitmap_dram_arbiter_nibble_merge.sv
// BITMODE nibble helpers: replace the selected nibble of a captured byte for the
// RMW write-back, and replicate the selected nibble of a read byte as {nib,nib}.
module bitmap_nibble_merge import bitmap_dram_arbiter_pkg::*; (
    input  logic [7:0] rmw_byte_i,
    input  logic [7:0] rd_byte_i,
    input  logic [3:0] pix_i,
    input  logic       pixa_i,
    output logic [7:0] merged_o,
    output logic [7:0] split_o
);

    // Nibble merge for writes and nibble replication for reads
    always_comb begin
        merged_o = rmw_byte_i;
        split_o  = rd_byte_i;
        if (pixa_i == NIB_HI) begin
            merged_o = {pix_i, rmw_byte_i[3:0]};
            split_o  = {rd_byte_i[7:4], rd_byte_i[7:4]};
        end else begin
            merged_o = {rmw_byte_i[7:4], pix_i};
            split_o  = {rd_byte_i[3:0], rd_byte_i[3:0]};
        end
    end

endmodule

// File: rtl/bitmap_dram_arbiter.sv
// Time-multiplexes the bitmap DRAM between video refresh fetches and CPU byte /
// BITMODE nibble accesses; BITMODE writes are an atomic read-modify-write.
module bitmap_dram_arbiter import bitmap_dram_arbiter_pkg::*; #(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int VID_MAX_WAIT = VID_MAX_WAIT_DEF
) (
    input logic                  clk,
    input logic                  reset,
    bitmap_dram_arbiter_if.slave bus
);

    state_e        state_q, state_d;
    logic          vid_pend_q, vid_pend_d;
    logic [AW-1:0] vid_addr_q, vid_addr_d;
    logic [DW-1:0] cap_q, cap_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_q, ram_we_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic [DW-1:0] vid_data_q, vid_data_d;
    logic          vid_valid_q, vid_valid_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic [DW-1:0] merged_s;
    logic [DW-1:0] split_s;

    bitmap_nibble_merge u_nibble (
        .rmw_byte_i (cap_q),
        .rd_byte_i  (bus.ram_rdata),
        .pix_i      (bus.cpu_wdata[7:4]),
        .pixa_i     (bus.cpu_pixa),
        .merged_o   (merged_s),
        .split_o    (split_s)
    );

    // Next-state and next-output logic; every output is the registered result
    // of the current state's action, so acks land in the following IDLE cycle.
    always_comb begin
        state_d     = state_q;
        vid_pend_d  = vid_pend_q;
        vid_addr_d  = vid_addr_q;
        cap_d       = cap_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        vid_data_d  = vid_data_q;
        vid_valid_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ack_d   = 1'b0;

        if (bus.vid_req) begin
            vid_pend_d = 1'b1;
            vid_addr_d = bus.vid_addr;
        end else begin
            vid_pend_d = vid_pend_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (vid_pend_d) begin
                    state_d    = ST_VRD;
                    ram_addr_d = vid_addr_d;
                    vid_pend_d = 1'b0;
                end else if (bus.cpu_req && !cpu_ack_q) begin
                    ram_addr_d = bus.cpu_addr;
                    if (!bus.cpu_we) begin
                        state_d = ST_CRD;
                    end else if (bus.cpu_bitmd) begin
                        state_d = ST_BRD;
                    end else begin
                        state_d = ST_CWR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_VRD:  state_d = ST_VCAP;
            ST_VCAP: begin
                vid_data_d  = bus.ram_rdata;
                vid_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_CRD:  state_d = ST_CCAP;
            ST_CCAP: begin
                if (bus.cpu_bitmd) begin
                    cpu_rdata_d = split_s;
                end else begin
                    cpu_rdata_d = bus.ram_rdata;
                end
                cpu_ack_d = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_CWR: begin
                ram_we_d    = 1'b1;
                ram_addr_d  = bus.cpu_addr;
                ram_wdata_d = bus.cpu_wdata;
                cpu_ack_d   = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_BRD:  state_d = ST_BCAP;
            ST_BCAP: begin
                cap_d   = bus.ram_rdata;
                state_d = ST_BWR;
            end
            ST_BWR: begin
                ram_we_d    = 1'b1;
                ram_wdata_d = merged_s;
                cpu_ack_d   = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            vid_pend_q  <= 1'b0;
            vid_addr_q  <= '0;
            cap_q       <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            vid_data_q  <= '0;
            vid_valid_q <= 1'b0;
            cpu_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vid_pend_q  <= vid_pend_d;
            vid_addr_q  <= vid_addr_d;
            cap_q       <= cap_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            vid_data_q  <= vid_data_d;
            vid_valid_q <= vid_valid_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
        end
    end

    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.vid_data  = vid_data_q;
    assign bus.vid_valid = vid_valid_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_ack   = cpu_ack_q;

    bitmap_dram_arbiter_chk #(.VID_MAX_WAIT(VID_MAX_WAIT)) u_chk (
        .clk       (clk),
        .reset     (reset),
        .vid_req   (bus.vid_req),
        .vid_pend  (vid_pend_q),
        .vid_valid (vid_valid_q)
    );

endmodule

// File: tb/tb_bitmap_dram_arbiter.sv
// Directed bench for bitmap_dram_arbiter with a 32Kx8 DRAM model (1-clk read latency).
module tb_bitmap_dram_arbiter;
    import bitmap_dram_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bitmap_dram_arbiter_if bus ();

    bitmap_dram_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0]  mem [0:32767];
    logic        pl_en = 1'b0;
    logic [14:0] pl_addr = 15'd0;
    logic [7:0]  pl_data = 8'd0;
    int          we_count = 0;
    int          passed = 0;
    int          total = 0;

    // DRAM model: writes from the arbiter (or bench preload), registered read
    always @(posedge clk) begin
        if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
            we_count <= we_count + 1;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic preload(input logic [14:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic cpu_op(input logic we, input logic bitmd, input logic pixa,
                          input logic [14:0] addr, input logic [7:0] wdata, input int hold,
                          output int lat, output int nacks, output logic [7:0] rdata);
        int drop_at;
        lat = -1; nacks = 0; rdata = 8'h00; drop_at = -1;
        @(negedge clk);
        bus.cpu_we = we; bus.cpu_bitmd = bitmd; bus.cpu_pixa = pixa;
        bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (bus.cpu_ack) begin
                nacks++;
                if (lat < 0) begin
                    lat = i; rdata = bus.cpu_rdata; drop_at = i + hold;
                end
            end
            if (i == drop_at) bus.cpu_req = 1'b0;
        end
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        int bad; int base;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (bus.vid_valid !== 1'b0) $display("FAIL reset_vid_valid: got %0h want 0", bus.vid_valid); else passed++;
        total++; if (bus.cpu_ack !== 1'b0) $display("FAIL reset_cpu_ack: got %0h want 0", bus.cpu_ack); else passed++;
        total++; if (bus.ram_we !== 1'b0) $display("FAIL reset_ram_we: got %0h want 0", bus.ram_we); else passed++;
        total++; if (bus.ram_addr !== 15'h0000) $display("FAIL reset_ram_addr: got %0h want 0", bus.ram_addr); else passed++;
        total++; if (bus.ram_wdata !== 8'h00) $display("FAIL reset_ram_wdata: got %0h want 0", bus.ram_wdata); else passed++;
        total++; if (bus.vid_data !== 8'h00) $display("FAIL reset_vid_data: got %0h want 0", bus.vid_data); else passed++;
        total++; if (bus.cpu_rdata !== 8'h00) $display("FAIL reset_cpu_rdata: got %0h want 0", bus.cpu_rdata); else passed++;
        bad = 0; base = we_count;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.ram_we !== 1'b0 || bus.cpu_ack !== 1'b0 || bus.vid_valid !== 1'b0) bad++;
        end
        total++; if (bad !== 0) $display("FAIL reset_idle_quiet: got %0d active cycles want 0", bad); else passed++;
        total++; if (we_count - base !== 0) $display("FAIL reset_no_we: got %0d writes want 0", we_count - base); else passed++;
    endtask

    task automatic test_cpu_read();
        int lat; int n; int base; logic [7:0] rd;
        preload(15'h1234, 8'hA5);
        base = we_count;
        cpu_op(1'b0, 1'b0, 1'b0, 15'h1234, 8'h00, 0, lat, n, rd);
        total++; if (lat !== 3) $display("FAIL read_latency: got %0d want 3", lat); else passed++;
        total++; if (rd !== 8'hA5) $display("FAIL read_data: got %0h want a5", rd); else passed++;
        total++; if (n !== 1) $display("FAIL read_ack_count: got %0d want 1", n); else passed++;
        total++; if (we_count - base !== 0) $display("FAIL read_no_we: got %0d want 0", we_count - base); else passed++;
    endtask

    task automatic test_bitmode_write();
        int lat; int n; logic [7:0] rd;
        preload(15'h2000, 8'h3C);
        cpu_op(1'b1, 1'b1, NIB_HI, 15'h2000, 8'h70, 0, lat, n, rd);
        total++; if (lat !== 4) $display("FAIL bm_wr_hi_latency: got %0d want 4", lat); else passed++;
        total++; if (mem[15'h2000] !== 8'h7C) $display("FAIL bm_wr_hi_data: got %0h want 7c", mem[15'h2000]); else passed++;
        preload(15'h2000, 8'h3C);
        cpu_op(1'b1, 1'b1, NIB_LO, 15'h2000, 8'h70, 0, lat, n, rd);
        total++; if (n !== 1) $display("FAIL bm_wr_lo_ack_count: got %0d want 1", n); else passed++;
        total++; if (mem[15'h2000] !== 8'h37) $display("FAIL bm_wr_lo_data: got %0h want 37", mem[15'h2000]); else passed++;
    endtask

    task automatic test_bitmode_read();
        int lat; int n; logic [7:0] rd;
        cpu_op(1'b0, 1'b1, NIB_HI, 15'h2000, 8'h00, 0, lat, n, rd);
        total++; if (rd !== 8'h33) $display("FAIL bm_rd_hi: got %0h want 33", rd); else passed++;
        cpu_op(1'b0, 1'b1, NIB_LO, 15'h2000, 8'h00, 0, lat, n, rd);
        total++; if (rd !== 8'h77) $display("FAIL bm_rd_lo: got %0h want 77", rd); else passed++;
    endtask

    task automatic test_ack_hold();
        int lat; int n; int base; logic [7:0] rd;
        base = we_count;
        cpu_op(1'b1, 1'b0, 1'b0, 15'h7FFF, 8'h5A, 1, lat, n, rd);
        total++; if (lat !== 2) $display("FAIL hold_latency: got %0d want 2", lat); else passed++;
        total++; if (n !== 1) $display("FAIL hold_ack_count: got %0d want 1", n); else passed++;
        total++; if (we_count - base !== 1) $display("FAIL hold_we_count: got %0d want 1", we_count - base); else passed++;
        total++; if (mem[15'h7FFF] !== 8'h5A) $display("FAIL hold_data: got %0h want 5a", mem[15'h7FFF]); else passed++;
    endtask

    task automatic test_vid_read();
        int vlat; logic [7:0] vd;
        preload(15'h0100, 8'h11);
        vlat = -1; vd = 8'h00;
        @(negedge clk);
        bus.vid_req = 1'b1; bus.vid_addr = 15'h0100;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) bus.vid_req = 1'b0;
            if (bus.vid_valid && vlat < 0) begin vlat = i; vd = bus.vid_data; end
        end
        total++; if (vlat !== 3) $display("FAIL vid_latency: got %0d want 3", vlat); else passed++;
        total++; if (vd !== 8'h11) $display("FAIL vid_data: got %0h want 11", vd); else passed++;
    endtask

    task automatic test_back_to_back();
        int vlat; int alat; int base; logic [7:0] vd;
        vlat = -1; alat = -1; vd = 8'h00; base = we_count;
        @(negedge clk);
        bus.vid_req = 1'b1; bus.vid_addr = 15'h0100;
        bus.cpu_we = 1'b1; bus.cpu_bitmd = 1'b0; bus.cpu_pixa = 1'b0;
        bus.cpu_addr = 15'h0200; bus.cpu_wdata = 8'h22; bus.cpu_req = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1) bus.vid_req = 1'b0;
            if (bus.vid_valid && vlat < 0) begin vlat = i; vd = bus.vid_data; end
            if (bus.cpu_ack && alat < 0) begin alat = i; bus.cpu_req = 1'b0; end
        end
        bus.cpu_req = 1'b0;
        total++; if (vlat !== 3) $display("FAIL simul_vid_latency: got %0d want 3", vlat); else passed++;
        total++; if (alat !== 5) $display("FAIL simul_ack_latency: got %0d want 5", alat); else passed++;
        total++; if (vd !== 8'h11) $display("FAIL simul_vid_data: got %0h want 11", vd); else passed++;
        total++; if (we_count - base !== 1) $display("FAIL simul_we_count: got %0d want 1", we_count - base); else passed++;
        total++; if (mem[15'h0200] !== 8'h22) $display("FAIL simul_wr_data: got %0h want 22", mem[15'h0200]); else passed++;
    endtask

    task automatic test_rmw_vid();
        int vlat; int alat; int base; logic [7:0] vd;
        preload(15'h3000, 8'hAB);
        preload(15'h0300, 8'h66);
        vlat = -1; alat = -1; vd = 8'h00; base = we_count;
        @(negedge clk);
        bus.cpu_we = 1'b1; bus.cpu_bitmd = 1'b1; bus.cpu_pixa = NIB_LO;
        bus.cpu_addr = 15'h3000; bus.cpu_wdata = 8'h50; bus.cpu_req = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1) begin bus.vid_req = 1'b1; bus.vid_addr = 15'h0300; end
            if (i == 2) bus.vid_req = 1'b0;
            if (bus.vid_valid && vlat < 0) begin vlat = i; vd = bus.vid_data; end
            if (bus.cpu_ack && alat < 0) begin alat = i; bus.cpu_req = 1'b0; end
        end
        bus.cpu_req = 1'b0;
        total++; if (alat !== 4) $display("FAIL rmw_ack_latency: got %0d want 4", alat); else passed++;
        total++; if (!(vlat > alat)) $display("FAIL rmw_vid_after_ack: got vid %0d ack %0d want vid later", vlat, alat); else passed++;
        total++; if (vlat < 0 || (vlat - 1) > VID_MAX_WAIT_DEF + 3) $display("FAIL rmw_vid_latency: got %0d want <= %0d", vlat - 1, VID_MAX_WAIT_DEF + 3); else passed++;
        total++; if (vd !== 8'h66) $display("FAIL rmw_vid_data: got %0h want 66", vd); else passed++;
        total++; if (mem[15'h3000] !== 8'hA5) $display("FAIL rmw_data: got %0h want a5", mem[15'h3000]); else passed++;
        total++; if (we_count - base !== 1) $display("FAIL rmw_we_count: got %0d want 1", we_count - base); else passed++;
    endtask

    task automatic test_reset_mid_rmw();
        int acks; int base;
        preload(15'h4000, 8'h12);
        acks = 0; base = we_count;
        @(negedge clk);
        bus.cpu_we = 1'b1; bus.cpu_bitmd = 1'b1; bus.cpu_pixa = NIB_HI;
        bus.cpu_addr = 15'h4000; bus.cpu_wdata = 8'hF0; bus.cpu_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; bus.cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.cpu_ack) acks++;
        end
        total++; if (acks !== 0) $display("FAIL midrst_ack: got %0d want 0", acks); else passed++;
        total++; if (we_count - base !== 0) $display("FAIL midrst_we: got %0d want 0", we_count - base); else passed++;
        total++; if (mem[15'h4000] !== 8'h12) $display("FAIL midrst_data: got %0h want 12", mem[15'h4000]); else passed++;
    endtask

    initial begin
        bus.vid_req = 1'b0; bus.vid_addr = 15'd0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_bitmd = 1'b0; bus.cpu_pixa = 1'b0;
        bus.cpu_addr = 15'd0; bus.cpu_wdata = 8'd0;
        test_reset();
        test_cpu_read();
        test_bitmode_write();
        test_bitmode_read();
        test_ack_hold();
        test_vid_read();
        test_back_to_back();
        test_rmw_vid();
        test_reset_mid_rmw();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
